// File: rtl/byte_packer.sv
// byte_packer: packs an 8-bit valid/ready byte stream little-endian into
// LANES-byte words. The output word carries a per-byte keep mask and a last flag.
// A word closes when it is full, or early when the input marks a packet end.
// Optional feature: define BYTE_PACKER_PARITY_EN to add m_parity_o, which gives
// even parity per kept byte and is registered alongside m_data_o.
module byte_packer #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid_i,
  input  logic [7:0]         s_data_i,
  input  logic               s_last_i,
  output logic               s_ready_o,
  output logic               m_valid_o,
  output logic [8*LANES-1:0] m_data_o,
  output logic [LANES-1:0]   m_keep_o,
  output logic               m_last_o,
`ifdef BYTE_PACKER_PARITY_EN
  output logic [LANES-1:0]   m_parity_o,
`endif
  input  logic               m_ready_i
);

  localparam int CW = $clog2(LANES);

  typedef enum logic {EMPTY, PARTIAL} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [8*LANES-1:0] acc_q, acc_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic               m_valid_q, m_valid_d;
  logic [8*LANES-1:0] m_data_q, m_data_d;
  logic [LANES-1:0]   m_keep_q, m_keep_d;
  logic               m_last_q, m_last_d;

  logic               in_acc;
  logic               close;
  logic [8*LANES-1:0] word;
  logic [LANES-1:0]   keep_new;

`ifdef BYTE_PACKER_PARITY_EN
  logic [LANES-1:0]   m_parity_q, m_parity_d;

  // Even parity of each byte lane; lanes outside the keep mask report 0.
  function automatic logic [LANES-1:0] lane_parity(input logic [8*LANES-1:0] w,
                                                   input logic [LANES-1:0]   k);
    logic [LANES-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i] = k[i] & (^w[8*i +: 8]);
    return p;
  endfunction
`endif

  // Handshake, word assembly, next-state and output-register next values.
  always_comb begin
    s_ready_o = !m_valid_q || m_ready_i;
    in_acc    = s_valid_i && s_ready_o;
    close     = in_acc && ((cnt_q == CW'(LANES - 1)) || s_last_i);

    // In EMPTY the accumulator is already clear; start from zero explicitly.
    word      = (state_q == EMPTY) ? '0 : acc_q;
    word[8*int'(cnt_q) +: 8] = s_data_i;
    keep_new  = ((state_q == EMPTY) ? '0 : mask_q) | (LANES'(1) << cnt_q);

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mask_d    = mask_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
`ifdef BYTE_PACKER_PARITY_EN
    m_parity_d = m_parity_q;
`endif

    if (in_acc) begin
      if (close) begin
        state_d = EMPTY;
        cnt_d   = '0;
        acc_d   = '0;
        mask_d  = '0;
      end else begin
        state_d = PARTIAL;
        cnt_d   = cnt_q + CW'(1);
        acc_d   = word;
        mask_d  = keep_new;
      end
    end

    // A closing byte reloads the output register even while the previous
    // word is being taken, so back-to-back words have no bubble.
    if (close) begin
      m_valid_d = 1'b1;
      m_data_d  = word;
      m_keep_d  = keep_new;
      m_last_d  = s_last_i;
`ifdef BYTE_PACKER_PARITY_EN
      m_parity_d = lane_parity(word, keep_new);
`endif
    end else if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  // State, accumulator and output registers; reset discards everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      acc_q     <= '0;
      mask_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
`ifdef BYTE_PACKER_PARITY_EN
      m_parity_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mask_q    <= mask_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
`ifdef BYTE_PACKER_PARITY_EN
      m_parity_q <= m_parity_d;
`endif
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_keep_o  = m_keep_q;
  assign m_last_o  = m_last_q;
`ifdef BYTE_PACKER_PARITY_EN
  assign m_parity_o = m_parity_q;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed scenarios plus randomized traffic for byte_packer.
// The reference model collects accepted bytes into a list. Each time the list
// fills or a last byte arrives, it turns the list into an expected word held in
// a queue.
module tb_byte_packer;

  localparam int LANES = 4;

  logic               clk;
  logic               reset;
  logic               s_valid_i;
  logic [7:0]         s_data_i;
  logic               s_last_i;
  logic               s_ready_o;
  logic               m_valid_o;
  logic [8*LANES-1:0] m_data_o;
  logic [LANES-1:0]   m_keep_o;
  logic               m_last_o;
  logic               m_ready_i;
`ifdef BYTE_PACKER_PARITY_EN
  logic [LANES-1:0]   m_parity_o;
`endif

  byte_packer #(.LANES(LANES)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_last_i  (s_last_i),
    .s_ready_o (s_ready_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_keep_o  (m_keep_o),
    .m_last_o  (m_last_o),
`ifdef BYTE_PACKER_PARITY_EN
    .m_parity_o(m_parity_o),
`endif
    .m_ready_i (m_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*LANES-1:0] data;
    logic [LANES-1:0]   keep;
    logic               last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] cur[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the DUT against
  // the model, then advance the model by whatever the next rising edge accepts.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic mr);
    logic  ready_exp;
    word_t w;
    int    n;
    @(negedge clk);
    s_valid_i = v;
    s_data_i  = d;
    s_last_i  = l;
    m_ready_i = mr;
    #1;
    ready_exp = (exp_q.size() == 0) || mr;
    check("s_ready", s_ready_o, ready_exp);
    check("m_valid", m_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("m_data", m_data_o, exp_q[0].data);
      check("m_keep", m_keep_o, exp_q[0].keep);
      check("m_last", m_last_o, exp_q[0].last);
`ifdef BYTE_PACKER_PARITY_EN
      begin
        logic [LANES-1:0] p;
        for (int k = 0; k < LANES; k++) p[k] = exp_q[0].keep[k] & (^exp_q[0].data[8*k +: 8]);
        check("m_parity", m_parity_o, p);
      end
`endif
      if (mr) void'(exp_q.pop_front());
    end
    if (v && ready_exp) begin
      cur.push_back(d);
      if (cur.size() == LANES || l) begin
        n      = cur.size();
        w.data = '0;
        for (int k = 0; k < n; k++) w.data[8*k +: 8] = cur[k];
        w.keep = LANES'((1 << n) - 1);
        w.last = l;
        exp_q.push_back(w);
        cur.delete();
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic apply_reset();
    @(negedge clk);
    s_valid_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_m_keep", m_keep_o, 0);
    check("rst_m_last", m_last_o, 0);
    check("rst_s_ready", s_ready_o, 1);
`ifdef BYTE_PACKER_PARITY_EN
    check("rst_m_parity", m_parity_o, 0);
`endif
    exp_q.delete();
    cur.delete();
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    m_ready_i = 1'b1;
    @(negedge clk);
    #1;
    check("init_m_valid", m_valid_o, 0);
    check("init_m_data", m_data_o, 0);
    check("init_m_keep", m_keep_o, 0);
    #1 reset = 1'b0;

    // Full word at full rate.
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    cycle(1, 8'h33, 0, 1);
    cycle(1, 8'h44, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Two-byte packet, then a byte that must start in lane 0.
    cycle(1, 8'hAA, 0, 1);
    cycle(1, 8'hBB, 1, 1);
    cycle(1, 8'hCC, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // Single-byte packet, then a full packet with last on the 4th byte.
    cycle(1, 8'h5A, 1, 1);
    cycle(1, 8'hD1, 0, 1);
    cycle(1, 8'hD2, 0, 1);
    cycle(1, 8'hD3, 0, 1);
    cycle(1, 8'hD4, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // Stall with a word pending and a closing byte waiting, then release.
    cycle(1, 8'hA1, 0, 1);
    cycle(1, 8'hA2, 0, 1);
    cycle(1, 8'hA3, 0, 1);
    cycle(1, 8'hA4, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'hB1, 1, 0);
    cycle(1, 8'hB1, 1, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Reset after two bytes; the next word must carry no residue.
    cycle(1, 8'h77, 0, 1);
    cycle(1, 8'h88, 0, 1);
    apply_reset();
    cycle(1, 8'h01, 0, 1);
    cycle(1, 8'h02, 0, 1);
    cycle(1, 8'h03, 0, 1);
    cycle(1, 8'h04, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Mixed-parity two-byte packet.
    cycle(1, 8'h03, 0, 1);
    cycle(1, 8'h07, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // Randomized traffic with back-pressure and one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
